alp_srcsel_seq: RTL and testbench
=================================

// Module: alp_srcsel_seq
// PURPOSE
//  Registered, multi-slice source-select sequencer for the ALP datapath. It latches the 4-bit
//  micro-op mux field and decodes it to per-slice one-hot A-mux selects and a shared one-hot
//  B-mux select. It runs the pad (P->A) request/acknowledge handshake, stalling the microsequencer
//  until pad data arrives or a timeout forces a fallback to MBUS. It sits between the micro-op
//  register and the NSLICE ALP slice datapaths.
// PARAMETERS
//  NSLICE    4   number of ALP slices; each slice has its own ext_ena bit and A-mux select
//  PAD_TMO   15  cycles spent in PADWAIT without pad_ack_h before timeout (1..2^TMO_W-1)
//  TMO_W     4   width of the timeout counter
// PORTS
//  clk_h          in   1         single clock; all state changes on the rising edge
//  reset_h        in   1         synchronous reset, active high
//  uop_valid_h    in   1         mux_h/ext_ena_h valid this cycle
//  mux_h          in   4         micro-op source code
//  ext_ena_h      in   NSLICE    per-slice extended-MBUS (pad) enable
//  pad_ack_h      in   1         pad data present; honoured only in PADWAIT
//  amux_onehot_h  out  4*NSLICE  per slice {R,M,D,P} (bit3..0), slice 0 in the LSBs
//  bmux_onehot_h  out  3         {R,Q,S} (bit2..0)
//  sel_valid_h    out  1         selects valid and final for this microcycle
//  pad_req_h      out  1         pad fetch request
//  stall_h        out  1         upstream must hold its micro-op; uop_valid_h is ignored
//  pad_err_h      out  1         one-cycle pulse on pad timeout
// BEHAVIOUR
//  Reset is one synchronous cycle with reset_h=1.
//   - All outputs go to 0, the state goes to IDLE and the counter is cleared.
//   - Reset wins over every other event, including during PADWAIT (pad_req_h drops next edge).
//  Decode table, per slice s, with E = ext_ena_h[s]. A-mux:
//   - 0000-0100  -> M
//   - 0101-0111  -> M if E=0, P if E=1
//   - 1000-1100  -> D
//   - 1101       -> none (0000)
//   - 1110-1111  -> R
//  Decode table, B-mux. Every code is exactly one-hot:
//   - R: 0000, 0001, 0101, 1000, 1001
//   - S: 0100, 0111, 1100, 1101, 1111
//   - Q: 0010, 0011, 0110, 1010, 1011, 1110
//  Latency is 1. Outputs are registered on the edge after uop_valid_h is sampled.
//  IDLE state:
//   - uop_valid_h=0: on the next edge the onehots go to 0, sel_valid_h=0 and pad_req_h=0.
//   - uop_valid_h=1, no slice decodes P: load the onehots, sel_valid_h=1, stay in IDLE.
//   - uop_valid_h=1, any slice decodes P: load the onehots, pad_req_h=1, stall_h=1,
//     sel_valid_h=0, counter cleared, go to PADWAIT.
//  PADWAIT state:
//   - The onehots are held and the counter increments every cycle.
//   - pad_ack_h=1: next edge pad_req_h=0, stall_h=0, sel_valid_h=1, go to IDLE. That cycle
//     is final.
//   - Counter reaches PAD_TMO-1 with no ack: next edge every slice with P becomes M (0100),
//     pad_err_h=1 for one cycle, pad_req_h=0, stall_h=0, sel_valid_h=1, go to IDLE.
//   - Ack and timeout in the same cycle: ack wins, so no pad_err_h.
//  The cycle after leaving PADWAIT:
//   - The block is in IDLE, sel_valid_h=1 and the next uop_valid_h is accepted.
//   - It is decoded into the following edge.
//  stall_h equals (state==PADWAIT) and is registered. uop_valid_h and mux_h are don't-care
//  while stall_h=1.
//  pad_ack_h is ignored in IDLE. A stray ack does not start or affect a later request.
//  At most one pad transaction is outstanding. pad_req_h is never reasserted back-to-back
//  without one intervening IDLE edge.
// STRUCTURE
//  Package alp_pkg:
//   - localparams for the 4-bit mux codes
//   - one-hot bit index constants: AM_R=3, AM_M=2, AM_D=1, AM_P=0, BM_R=2, BM_Q=1, BM_S=0
//   - typedef enum {IDLE, PADWAIT} alp_srcsel_st_t
//  Sub-module alp_srcdec: combinational single-slice decoder (mux_h, ext_ena_h -> amux[3:0],
//  bmux[2:0]). It is instantiated NSLICE times in a generate loop; B-mux is taken from slice 0.
//  The FSM, counter and output registers live in the top module.
// TESTING
//  1 Assert reset_h for 1 cycle with junk on the inputs -> all outputs 0, state IDLE.
//  2 NSLICE=4, mux_h=1110, ext=0000, valid=1 -> next cycle amux=16'h8888, bmux=3'b010,
//    sel_valid_h=1, pad_req_h=0.
//  3 mux_h=0110, ext=0011 -> amux=16'h4411, bmux=010, pad_req_h=1, stall_h=1.
//    Then pad_ack_h on the 3rd PADWAIT cycle -> next edge pad_req_h=0, stall_h=0,
//    sel_valid_h=1, amux still 16'h4411.
//  4 mux_h=0101, ext=1111, no ack -> stall_h=1 for exactly 15 cycles, then pad_err_h pulses
//    one cycle, amux=16'h4444, bmux=100.
//  5 Ack on the final timeout cycle -> no pad_err_h, P selects kept.
//    Reset asserted in PADWAIT cycle 5 -> next edge all outputs 0, and a later ack is ignored.
//  6 Sweep all 16 codes x ext in {0,1}, back-to-back, acking every P within 1 cycle:
//    - every output matches the decode table
//    - bmux is always one-hot
//    - 1101 gives amux 0000

Source files
------------

// File: rtl/alp_srcsel_seq_pkg.sv
// Shared constants for the ALP source-select sequencer: mux-code boundaries,
// one-hot bit positions and the sequencer state type.
package alp_pkg;

  // Upper bounds of the contiguous A-mux decode ranges
  localparam logic [3:0] MUX_M_MAX   = 4'h4;
  localparam logic [3:0] MUX_EXT_MAX = 4'h7;
  localparam logic [3:0] MUX_D_MAX   = 4'hC;
  localparam logic [3:0] MUX_NONE    = 4'hD;

  localparam int AM_R = 3;
  localparam int AM_M = 2;
  localparam int AM_D = 1;
  localparam int AM_P = 0;

  localparam int BM_R = 2;
  localparam int BM_Q = 1;
  localparam int BM_S = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    PADWAIT = 1'b1
  } alp_srcsel_st_t;

  // A timed-out pad fetch falls back to MBUS for that slice
  function automatic logic [3:0] pad_to_mbus(input logic [3:0] sel);
    logic [3:0] res;
    res = sel;
    if (sel[AM_P]) begin
      res       = '0;
      res[AM_M] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/alp_srcsel_seq_if.sv
// Micro-op in / select-and-handshake out bundle between the micro-op register,
// the source-select sequencer and the ALP slices.
interface alp_srcsel_seq_if #(
  parameter int NSLICE = 4
);
  logic                  uop_valid_h;
  logic [3:0]            mux_h;
  logic [NSLICE-1:0]     ext_ena_h;
  logic                  pad_ack_h;
  logic [4*NSLICE-1:0]   amux_onehot_h;
  logic [2:0]            bmux_onehot_h;
  logic                  sel_valid_h;
  logic                  pad_req_h;
  logic                  stall_h;
  logic                  pad_err_h;

  modport master (
    output uop_valid_h, mux_h, ext_ena_h, pad_ack_h,
    input  amux_onehot_h, bmux_onehot_h, sel_valid_h, pad_req_h, stall_h, pad_err_h
  );

  modport slave (
    input  uop_valid_h, mux_h, ext_ena_h, pad_ack_h,
    output amux_onehot_h, bmux_onehot_h, sel_valid_h, pad_req_h, stall_h, pad_err_h
  );
endinterface

// File: rtl/alp_srcsel_seq_srcdec.sv
// Combinational single-slice decoder: micro-op mux code plus the slice's
// extended-MBUS enable to one-hot A-mux and B-mux selects.
module alp_srcdec
  import alp_pkg::*;
(
  input  logic [3:0] mux_i,
  input  logic       ext_ena_i,
  output logic [3:0] amux_o,
  output logic [2:0] bmux_o
);

  always_comb begin
    amux_o = '0;
    if (mux_i <= MUX_M_MAX) begin
      amux_o[AM_M] = 1'b1;
    end else if (mux_i <= MUX_EXT_MAX) begin
      if (ext_ena_i) amux_o[AM_P] = 1'b1;
      else           amux_o[AM_M] = 1'b1;
    end else if (mux_i <= MUX_D_MAX) begin
      amux_o[AM_D] = 1'b1;
    end else if (mux_i != MUX_NONE) begin
      amux_o[AM_R] = 1'b1;
    end
  end

  always_comb begin
    bmux_o = '0;
    case (mux_i)
      4'h0, 4'h1, 4'h5, 4'h8, 4'h9: bmux_o[BM_R] = 1'b1;
      4'h4, 4'h7, 4'hC, 4'hD, 4'hF: bmux_o[BM_S] = 1'b1;
      default:                      bmux_o[BM_Q] = 1'b1;
    endcase
  end

endmodule

// File: rtl/alp_srcsel_seq.sv
// Registered source-select sequencer: decodes micro-op mux codes for all slices
// and runs the pad request/ack handshake with timeout fallback to MBUS.
module alp_srcsel_seq
  import alp_pkg::*;
#(
  parameter int NSLICE  = 4,
  parameter int PAD_TMO = 15,
  parameter int TMO_W   = 4
) (
  input  logic            clk_h,
  input  logic            reset_h,
  alp_srcsel_seq_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PAD_TMO - 1);

  logic [4*NSLICE-1:0] amux_dec;
  logic [2:0]          bmux_sl [NSLICE];
  logic [2:0]          bmux_dec;
  logic                any_pad;

  alp_srcsel_st_t      state_q, state_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [4*NSLICE-1:0] amux_q, amux_d;
  logic [2:0]          bmux_q, bmux_d;
  logic                sel_valid_q, sel_valid_d;
  logic                pad_req_q, pad_req_d;
  logic                pad_err_q, pad_err_d;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    alp_srcdec u_dec (
      .mux_i     (bus.mux_h),
      .ext_ena_i (bus.ext_ena_h[s]),
      .amux_o    (amux_dec[4*s +: 4]),
      .bmux_o    (bmux_sl[s])
    );
  end

  // Every slice sees the same code, so all B decodes agree; OR-ing them equals slice 0's.
  always_comb begin
    bmux_dec = bmux_sl[0];
    any_pad  = 1'b0;
    for (int s = 0; s < NSLICE; s++) begin
      bmux_dec = bmux_dec | bmux_sl[s];
      any_pad  = any_pad | amux_dec[4*s + AM_P];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    amux_d      = amux_q;
    bmux_d      = bmux_q;
    sel_valid_d = sel_valid_q;
    pad_req_d   = pad_req_q;
    pad_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.uop_valid_h) begin
          amux_d = amux_dec;
          bmux_d = bmux_dec;
          if (any_pad) begin
            pad_req_d   = 1'b1;
            sel_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = PADWAIT;
          end else begin
            pad_req_d   = 1'b0;
            sel_valid_d = 1'b1;
          end
        end else begin
          amux_d      = '0;
          bmux_d      = '0;
          sel_valid_d = 1'b0;
          pad_req_d   = 1'b0;
        end
      end
      PADWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.pad_ack_h) begin
          pad_req_d   = 1'b0;
          sel_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          for (int s = 0; s < NSLICE; s++) begin
            amux_d[4*s +: 4] = pad_to_mbus(amux_q[4*s +: 4]);
          end
          pad_err_d   = 1'b1;
          pad_req_d   = 1'b0;
          sel_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      amux_q      <= '0;
      bmux_q      <= '0;
      sel_valid_q <= 1'b0;
      pad_req_q   <= 1'b0;
      pad_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      amux_q      <= amux_d;
      bmux_q      <= bmux_d;
      sel_valid_q <= sel_valid_d;
      pad_req_q   <= pad_req_d;
      pad_err_q   <= pad_err_d;
    end
  end

  assign bus.amux_onehot_h = amux_q;
  assign bus.bmux_onehot_h = bmux_q;
  assign bus.sel_valid_h   = sel_valid_q;
  assign bus.pad_req_h     = pad_req_q;
  assign bus.stall_h       = (state_q == PADWAIT);
  assign bus.pad_err_h     = pad_err_q;

endmodule

// File: tb/tb_alp_srcsel_seq.sv
// Directed self-checking bench for alp_srcsel_seq: reset, decode, pad ack,
// timeout, ack-at-timeout, reset during PADWAIT and a full code sweep.
module tb_alp_srcsel_seq;

  logic clk_h = 1'b0;
  logic reset_h;
  int   total = 0;
  int   bad   = 0;

  alp_srcsel_seq_if #(.NSLICE(4)) bus ();

  alp_srcsel_seq #(.NSLICE(4), .PAD_TMO(15), .TMO_W(4)) dut (
    .clk_h   (clk_h),
    .reset_h (reset_h),
    .bus     (bus)
  );

  always #5 clk_h = ~clk_h;

  // Inputs change at the falling edge, outputs are sampled at the falling edge after the next rise.
  task automatic step();
    @(posedge clk_h);
    @(negedge clk_h);
  endtask

  task automatic test_reset();
    @(negedge clk_h);
    reset_h = 1'b1;
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'h5; bus.ext_ena_h = 4'hF; bus.pad_ack_h = 1'b1;
    step();
    reset_h = 1'b0; bus.uop_valid_h = 1'b0; bus.pad_ack_h = 1'b0;
    total++; if (bus.amux_onehot_h !== 16'h0) begin bad++; $display("FAIL reset_amux got=%h exp=0000", bus.amux_onehot_h); end
    total++; if (bus.bmux_onehot_h !== 3'b000) begin bad++; $display("FAIL reset_bmux got=%b exp=000", bus.bmux_onehot_h); end
    total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h}); end
  endtask

  task automatic test_decode_r();
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'hE; bus.ext_ena_h = 4'h0;
    step();
    bus.uop_valid_h = 1'b0;
    total++; if (bus.amux_onehot_h !== 16'h8888) begin bad++; $display("FAIL r_amux got=%h exp=8888", bus.amux_onehot_h); end
    total++; if (bus.bmux_onehot_h !== 3'b010) begin bad++; $display("FAIL r_bmux got=%b exp=010", bus.bmux_onehot_h); end
    total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h} !== 3'b100) begin
      bad++; $display("FAIL r_flags got=%b exp=100", {bus.sel_valid_h, bus.pad_req_h, bus.stall_h}); end
    step();
    total++; if ({bus.amux_onehot_h, bus.sel_valid_h} !== 17'h0) begin
      bad++; $display("FAIL idle_clear got=%h/%b exp=0000/0", bus.amux_onehot_h, bus.sel_valid_h); end
  endtask

  task automatic test_pad_ack();
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'h6; bus.ext_ena_h = 4'h3;
    step();
    bus.uop_valid_h = 1'b0;
    total++; if (bus.amux_onehot_h !== 16'h4411) begin bad++; $display("FAIL ack_amux got=%h exp=4411", bus.amux_onehot_h); end
    total++; if (bus.bmux_onehot_h !== 3'b010) begin bad++; $display("FAIL ack_bmux got=%b exp=010", bus.bmux_onehot_h); end
    total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h} !== 3'b011) begin
      bad++; $display("FAIL ack_enter got=%b exp=011", {bus.sel_valid_h, bus.pad_req_h, bus.stall_h}); end
    step();
    step();
    total++; if (bus.stall_h !== 1'b1) begin bad++; $display("FAIL ack_cyc3_stall got=%b exp=1", bus.stall_h); end
    bus.pad_ack_h = 1'b1;
    step();
    bus.pad_ack_h = 1'b0;
    total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h} !== 4'b1000) begin
      bad++; $display("FAIL ack_leave got=%b exp=1000", {bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h}); end
    total++; if (bus.amux_onehot_h !== 16'h4411) begin bad++; $display("FAIL ack_hold got=%h exp=4411", bus.amux_onehot_h); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'h5; bus.ext_ena_h = 4'hF;
    step();
    bus.uop_valid_h = 1'b0;
    total++; if (bus.amux_onehot_h !== 16'h1111) begin bad++; $display("FAIL tmo_amux_p got=%h exp=1111", bus.amux_onehot_h); end
    n = (bus.stall_h === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && bus.stall_h === 1'b1; i++) begin
      step();
      if (bus.stall_h === 1'b1) n++;
    end
    total++; if (n !== 15) begin bad++; $display("FAIL tmo_stall_len got=%0d exp=15", n); end
    total++; if (bus.pad_err_h !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", bus.pad_err_h); end
    total++; if (bus.amux_onehot_h !== 16'h4444) begin bad++; $display("FAIL tmo_amux got=%h exp=4444", bus.amux_onehot_h); end
    total++; if (bus.bmux_onehot_h !== 3'b100) begin bad++; $display("FAIL tmo_bmux got=%b exp=100", bus.bmux_onehot_h); end
    total++; if ({bus.sel_valid_h, bus.pad_req_h} !== 2'b10) begin
      bad++; $display("FAIL tmo_flags got=%b exp=10", {bus.sel_valid_h, bus.pad_req_h}); end
    step();
    total++; if (bus.pad_err_h !== 1'b0) begin bad++; $display("FAIL tmo_err_pulse got=%b exp=0", bus.pad_err_h); end
  endtask

  task automatic test_ack_at_timeout();
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'h5; bus.ext_ena_h = 4'h1;
    step();
    bus.uop_valid_h = 1'b0;
    for (int i = 0; i < 14; i++) step();
    total++; if (bus.stall_h !== 1'b1) begin bad++; $display("FAIL last_cyc_stall got=%b exp=1", bus.stall_h); end
    bus.pad_ack_h = 1'b1;
    step();
    bus.pad_ack_h = 1'b0;
    total++; if (bus.pad_err_h !== 1'b0) begin bad++; $display("FAIL ackwin_err got=%b exp=0", bus.pad_err_h); end
    total++; if (bus.amux_onehot_h !== 16'h4441) begin bad++; $display("FAIL ackwin_amux got=%h exp=4441", bus.amux_onehot_h); end
    total++; if ({bus.sel_valid_h, bus.stall_h} !== 2'b10) begin
      bad++; $display("FAIL ackwin_flags got=%b exp=10", {bus.sel_valid_h, bus.stall_h}); end
    step();
  endtask

  task automatic test_reset_in_padwait();
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'h7; bus.ext_ena_h = 4'h2;
    step();
    bus.uop_valid_h = 1'b0;
    total++; if (bus.amux_onehot_h !== 16'h4414 || bus.bmux_onehot_h !== 3'b001) begin
      bad++; $display("FAIL rstpw_enter got=%h/%b exp=4414/001", bus.amux_onehot_h, bus.bmux_onehot_h); end
    for (int i = 0; i < 4; i++) step();
    reset_h = 1'b1;
    step();
    reset_h = 1'b0;
    total++; if ({bus.amux_onehot_h, bus.bmux_onehot_h, bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h} !== 23'h0) begin
      bad++; $display("FAIL rstpw_clear got=%h/%b/%b%b%b%b exp=all zero", bus.amux_onehot_h, bus.bmux_onehot_h,
                      bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h); end
    bus.pad_ack_h = 1'b1;
    step();
    bus.pad_ack_h = 1'b0;
    total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h} !== 4'b0000) begin
      bad++; $display("FAIL stray_ack got=%b exp=0000", {bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h}); end
    bus.uop_valid_h = 1'b1; bus.mux_h = 4'h0; bus.ext_ena_h = 4'hF;
    step();
    bus.uop_valid_h = 1'b0;
    total++; if (bus.amux_onehot_h !== 16'h4444 || {bus.sel_valid_h, bus.pad_req_h} !== 2'b10) begin
      bad++; $display("FAIL after_stray got=%h/%b exp=4444/10", bus.amux_onehot_h, {bus.sel_valid_h, bus.pad_req_h}); end
  endtask

  task automatic test_back_to_back_sweep();
    logic [3:0] am_e0 [16];
    logic [3:0] am_e1 [16];
    logic [2:0] bm    [16];
    logic [3:0] nib;
    logic [15:0] exp_a;
    am_e0 = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
              4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8};
    am_e1 = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1, 4'h1,
              4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8};
    bm    = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001,
              3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b010, 3'b001};
    for (int c = 0; c < 16; c++) begin
      for (int e = 0; e < 2; e++) begin
        nib   = (e == 1) ? am_e1[c] : am_e0[c];
        exp_a = {4{nib}};
        bus.uop_valid_h = 1'b1; bus.mux_h = 4'(c); bus.ext_ena_h = (e == 1) ? 4'hF : 4'h0;
        step();
        bus.uop_valid_h = 1'b0;
        total++; if (bus.amux_onehot_h !== exp_a) begin
          bad++; $display("FAIL sweep_amux code=%h e=%0d got=%h exp=%h", c, e, bus.amux_onehot_h, exp_a); end
        total++; if (bus.bmux_onehot_h !== bm[c] || !$onehot(bus.bmux_onehot_h)) begin
          bad++; $display("FAIL sweep_bmux code=%h e=%0d got=%b exp=%b", c, e, bus.bmux_onehot_h, bm[c]); end
        if (nib == 4'h1) begin
          total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h} !== 3'b011) begin
            bad++; $display("FAIL sweep_padreq code=%h got=%b exp=011", c, {bus.sel_valid_h, bus.pad_req_h, bus.stall_h}); end
          bus.pad_ack_h = 1'b1;
          step();
          bus.pad_ack_h = 1'b0;
          total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h} !== 4'b1000 ||
                       bus.amux_onehot_h !== exp_a) begin
            bad++; $display("FAIL sweep_padack code=%h got=%b/%h exp=1000/%h", c,
                            {bus.sel_valid_h, bus.pad_req_h, bus.stall_h, bus.pad_err_h}, bus.amux_onehot_h, exp_a); end
        end else begin
          total++; if ({bus.sel_valid_h, bus.pad_req_h, bus.stall_h} !== 3'b100) begin
            bad++; $display("FAIL sweep_flags code=%h e=%0d got=%b exp=100", c, e, {bus.sel_valid_h, bus.pad_req_h, bus.stall_h}); end
        end
      end
    end
    step();
  endtask

  initial begin
    reset_h = 1'b0;
    bus.uop_valid_h = 1'b0; bus.mux_h = 4'h0; bus.ext_ena_h = 4'h0; bus.pad_ack_h = 1'b0;
    test_reset();
    test_decode_r();
    test_pad_ack();
    test_timeout();
    test_ack_at_timeout();
    test_reset_in_padwait();
    test_back_to_back_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
